// File: rtl/barrett_mc.sv
// Multi-channel Barrett reducer: C mod q against one of NCH programmable moduli.
// Six register levels (S1..S5 plus output) under stall-all valid/ready flow control.
module barrett_mc #(
  parameter int LOGQ = 32,
  parameter int NCH  = 4,
  parameter int TAGW = 8,
  localparam int LOGC    = 2 * LOGQ,
  localparam int LOGLOGQ = $clog2(LOGQ + 1),
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [CHW-1:0]     cfg_ch,
  input  logic [LOGQ-1:0]    cfg_q,
  input  logic [LOGQ:0]      cfg_mu,
  input  logic [LOGLOGQ-1:0] cfg_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LOGC-1:0]    in_c,
  input  logic [CHW-1:0]     in_ch,
  input  logic [TAGW-1:0]    in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOGQ-1:0]    out_t,
  output logic [CHW-1:0]     out_ch,
  output logic [TAGW-1:0]    out_tag,
  output logic               out_err
);
  localparam int LW  = LOGQ + 2;
  localparam int T0W = 2 * LOGQ + 1;

  logic adv, accept, in_ch_ok;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rst_n;
  assign accept   = in_valid && in_ready;
  assign in_ch_ok = ({1'b0, in_ch} < (CHW + 1)'(NCH));

  logic [LOGQ-1:0]    tab_q  [NCH];
  logic [LOGQ:0]      tab_mu [NCH];
  logic [LOGLOGQ-1:0] tab_b  [NCH];
  logic [NCH-1:0]     tab_ok;

  // Out-of-range cfg_ch matches no entry, so such writes fall away naturally.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic               wr_sel;
      logic [LOGQ-1:0]    q_reg;
      logic [LOGQ:0]      mu_reg;
      logic [LOGLOGQ-1:0] b_reg;
      logic               ok_reg;
      assign wr_sel = cfg_we && (cfg_ch == CHW'(gi));
      always_ff @(posedge clk) begin
        if (wr_sel) begin
          q_reg  <= cfg_q;
          mu_reg <= cfg_mu;
          b_reg  <= cfg_b;
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ok_reg <= 1'b0;
        else if (wr_sel) ok_reg <= 1'b1;
      end
      assign tab_q[gi]  = q_reg;
      assign tab_mu[gi] = mu_reg;
      assign tab_b[gi]  = b_reg;
      assign tab_ok[gi] = ok_reg;
    end
  endgenerate

  logic s1_valid, s2_valid, s3_valid, s4_valid, s5_valid;
  logic [CHW-1:0]  s1_ch, s2_ch, s3_ch, s4_ch, s5_ch;
  logic [TAGW-1:0] s1_tag, s2_tag, s3_tag, s4_tag, s5_tag;
  logic            s1_err, s2_err, s3_err, s4_err, s5_err;

  logic [LOGC-1:0]    s1_c;
  logic [LOGQ-1:0]    s1_q, s2_q, s3_q, s4_q;
  logic [LOGQ:0]      s1_mu;
  logic [LOGLOGQ-1:0] s1_b, s2_b;
  logic [T0W-1:0]     s2_t0;
  logic [LW-1:0]      s2_c, s3_c, s3_qhq, s4_r;
  logic [LOGQ-1:0]    s5_r, s5_d1, s5_d2;
  logic               s5_ge1, s5_ge2;

  logic [LOGQ-1:0] s1_hi, t_sel;
  logic [LW-1:0]   s2_qh;
  // Only the low LW bits of C and of Qh*q matter: R is defined modulo 2^LW.
  assign s1_hi = LOGQ'(s1_c >> s1_b);
  assign s2_qh = LW'(s2_t0 >> s2_b);
  assign t_sel = s5_err ? '0 : (s5_ge2 ? s5_d2 : (s5_ge1 ? s5_d1 : s5_r));

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_c   <= in_c;
      s1_ch  <= in_ch;
      s1_tag <= in_tag;
      s1_err <= !(in_ch_ok && tab_ok[in_ch]);
      s1_q   <= tab_q[in_ch];
      s1_mu  <= tab_mu[in_ch];
      s1_b   <= tab_b[in_ch];

      s2_t0  <= T0W'(s1_hi) * T0W'(s1_mu);
      s2_c   <= LW'(s1_c);
      s2_q   <= s1_q;
      s2_b   <= s1_b;
      s2_ch  <= s1_ch;
      s2_tag <= s1_tag;
      s2_err <= s1_err;

      s3_qhq <= s2_qh * LW'(s2_q);
      s3_c   <= s2_c;
      s3_q   <= s2_q;
      s3_ch  <= s2_ch;
      s3_tag <= s2_tag;
      s3_err <= s2_err;

      s4_r   <= s3_c - s3_qhq;
      s4_q   <= s3_q;
      s4_ch  <= s3_ch;
      s4_tag <= s3_tag;
      s4_err <= s3_err;

      s5_r   <= LOGQ'(s4_r);
      s5_d1  <= LOGQ'(s4_r - LW'(s4_q));
      s5_d2  <= LOGQ'(s4_r - (LW'(s4_q) << 1));
      s5_ge1 <= (s4_r >= LW'(s4_q));
      s5_ge2 <= (s4_r >= (LW'(s4_q) << 1));
      s5_ch  <= s4_ch;
      s5_tag <= s4_tag;
      s5_err <= s4_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s4_valid  <= 1'b0;
      s5_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_t     <= '0;
      out_ch    <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      s4_valid  <= s3_valid;
      s5_valid  <= s4_valid;
      out_valid <= s5_valid;
      out_t     <= t_sel;
      out_ch    <= s5_ch;
      out_tag   <= s5_tag;
      out_err   <= s5_err;
    end
  end
endmodule

// File: tb/tb_barrett_mc.sv
// Bench for barrett_mc: stimulus pushes expected results computed as C % q into a
// scoreboard; a negedge monitor pops and compares every accepted output.
module tb_barrett_mc;
  localparam int LOGQ = 32, NCH = 4, TAGW = 8, LOGC = 64, LOGLOGQ = 6, CHW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [LOGQ-1:0] cfg_q = '0;
  logic [LOGQ:0] cfg_mu = '0;
  logic [LOGLOGQ-1:0] cfg_b = '0;
  logic in_valid = 1'b0, in_ready;
  logic [LOGC-1:0] in_c = '0;
  logic [CHW-1:0] in_ch = '0;
  logic [TAGW-1:0] in_tag = '0;
  logic out_valid, out_ready = 1'b1;
  logic [LOGQ-1:0] out_t;
  logic [CHW-1:0] out_ch;
  logic [TAGW-1:0] out_tag;
  logic out_err;

  barrett_mc #(.LOGQ(LOGQ), .NCH(NCH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_q(cfg_q), .cfg_mu(cfg_mu), .cfg_b(cfg_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c), .in_ch(in_ch), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_t(out_t), .out_ch(out_ch),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [LOGQ-1:0] t;
    logic [CHW-1:0]  ch;
    logic [TAGW-1:0] tag;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int pop_cyc[$];
  int checks = 0;
  int passes = 0;
  longint unsigned m_q[NCH];
  bit m_ok[NCH];
  bit rand_run = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic exp_t model(logic [63:0] c, int ch, logic [TAGW-1:0] tag);
    exp_t e;
    e.ch  = CHW'(ch);
    e.tag = tag;
    e.err = !m_ok[ch];
    e.t   = m_ok[ch] ? LOGQ'(c % m_q[ch]) : '0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got ch=%0d tag=%0d t=%0d, expected no output", out_ch, out_tag, out_t);
      end else begin
        e = sb.pop_front();
        $display("result @%0d ch=%0d tag=%02h t=%0d err=%0d", cyc, out_ch, out_tag, out_t, out_err);
        check("out_t", out_t, e.t);
        check("out_ch", out_ch, e.ch);
        check("out_tag", out_tag, e.tag);
        check("out_err", out_err, e.err);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic cfg(int ch, longint unsigned q, logic [LOGQ:0] mu, int b);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_q = LOGQ'(q); cfg_mu = mu; cfg_b = LOGLOGQ'(b);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_q[ch] = q;
    m_ok[ch] = 1'b1;
  endtask

  task automatic send(logic [63:0] c, int ch, logic [TAGW-1:0] tag);
    int n = 0;
    in_valid = 1'b1; in_c = c; in_ch = CHW'(ch); in_tag = tag;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(c, ch, tag));
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 300) begin
        checks++;
        $display("FAIL send_timeout: in_ready stayed 0, expected acceptance");
        @(posedge clk); #1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_outstanding", sb.size(), 0);
  endtask

  task automatic rand_cfg(int ch);
    int b;
    longint unsigned lo, hi, q;
    logic [127:0] num;
    b  = $urandom_range(2, 32);
    lo = (64'd1 << (b - 1)) + 1;
    hi = (64'd1 << b) - 1;
    q  = lo + (longint'($urandom) % (hi - lo + 1));
    num = 128'(1) << (2 * b);
    cfg(ch, q, (LOGQ + 1)'(num / 128'(q)), b);
  endtask

  function automatic logic [63:0] rand_c(int ch);
    logic [63:0] c;
    int b;
    b = $clog2(m_q[ch] + 1);
    c = {$urandom(), $urandom()};
    if (2 * b < 64) c = c & ((64'd1 << (2 * b)) - 1);
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [LOGQ-1:0] h_t;
    logic [TAGW-1:0] h_tag;
    logic [CHW-1:0] h_ch;
    longint unsigned qb;
    int n;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_t", out_t, 0);
    check("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;

    // basic reduction and latency
    cfg(0, 17, 60, 5);
    send(288, 0, 8'h5A);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      check("latency_valid", out_valid, (i == 5));
    end
    send(0, 0, 8'h01);
    drain();

    // full-width modulus
    qb = 64'd4294967291;
    cfg(3, qb, 33'd4294967301, 32);
    send(64'hFFFF_FFFF_FFFF_FFFF, 3, 8'h10);
    send(qb * (qb - 1), 3, 8'h11);
    drain();

    // interleaved channels at full rate
    cfg(1, 97, 168, 7);
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) send(64'($urandom_range(0, 1023)), 0, 8'(8'h20 + i));
      else            send(64'($urandom_range(0, 16383)), 1, 8'(8'h20 + i));
    end
    drain();
    check("b2b_count", pop_cyc.size(), 16);
    if (pop_cyc.size() == 16) check("b2b_span", pop_cyc[15] - pop_cyc[0], 15);

    // backpressure
    for (int i = 0; i < 5; i++) send(64'($urandom_range(0, 16383)), 1, 8'(8'h40 + i));
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", out_valid, 1);
    out_ready = 1'b0;
    h_t = out_t; h_tag = out_tag; h_ch = out_ch;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_t", out_t, h_t);
      check("bp_hold_tag", out_tag, h_tag);
      check("bp_hold_ch", out_ch, h_ch);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // config race and unconfigured channel
    cfg_we = 1'b1; cfg_ch = 0; cfg_q = 97; cfg_mu = 168; cfg_b = 7;
    send(288, 0, 8'h50);
    cfg_we = 1'b0;
    m_q[0] = 97;
    send(288, 0, 8'h51);
    send(64'd12345, 2, 8'h52);
    drain();

    // randomized traffic with random backpressure
    for (int ch = 0; ch < NCH; ch++) rand_cfg(ch);
    rand_run = 1'b1;
    fork
      while (rand_run) begin
        @(posedge clk); #1;
        if (rand_run) out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 80; i++) begin
      int ch;
      ch = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(rand_c(ch), ch, 8'($urandom));
    end
    rand_run = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // asynchronous reset with operations in flight
    for (int i = 0; i < 4; i++) send(rand_c(0), 0, 8'(8'h60 + i));
    out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("pre_reset_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    sb.delete();
    for (int ch = 0; ch < NCH; ch++) m_ok[ch] = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_t", out_t, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
    end
    send(64'd100, 0, 8'h70);
    drain();
    cfg(0, 17, 60, 5);
    send(64'd100, 0, 8'h71);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
